// File: rtl/stoch_pkg.sv
// Shared definitions for the triple-stream stochastic bit generator.
// Holds the default width, feedback mask and per-stream seeds, the
// frame length helper and the FSM state encoding.
package stoch_pkg;

    localparam int         WIDTH_DEF = 8;
    localparam logic [7:0] TAPS_DEF  = 8'b1011_1000;
    localparam logic [7:0] SEED0_DEF = 8'h01;
    localparam logic [7:0] SEED1_DEF = 8'h5A;
    localparam logic [7:0] SEED2_DEF = 8'hC3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One frame is a full period of a maximal-length LFSR of this width.
    function automatic int frame_len(input int width);
        return (32'sd1 <<< width) - 32'sd1;
    endfunction

endpackage

// File: rtl/stoch_lfsr.sv
// Fibonacci LFSR, shift-left with feedback into bit 0.
// Ports:
//   CLK  - rising-edge clock
//   INIT - synchronous active-high reset, loads SEED
//   EN   - advance one step this edge
//   Q    - current register contents
module stoch_lfsr
    import stoch_pkg::*;
#(
    parameter int               WIDTH = WIDTH_DEF,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_DEF,
    parameter logic [WIDTH-1:0] SEED  = SEED0_DEF
) (
    input  logic             CLK,
    input  logic             INIT,
    input  logic             EN,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] lfsr_r;
    logic             fb_s;

    // Feedback is the parity of the tapped bits.
    always_comb begin
        fb_s = ^(lfsr_r & TAPS);
    end

    // State register: reseeded only by INIT, otherwise held across frames.
    always_ff @(posedge CLK) begin
        if (INIT) begin
            lfsr_r <= SEED;
        end else if (EN) begin
            lfsr_r <= {lfsr_r[WIDTH-2:0], fb_s};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign Q = lfsr_r;

endmodule

// File: rtl/stoch_bitgen3.sv
// Binary-to-stochastic encoder producing three independent bitstreams.
// Each LOAD starts a frame of exactly one LFSR period; stream i emits a 1
// whenever (lfsr_i - 1) < value, so each frame holds exactly VALUE ones.
// Ports:
//   CLK    - rising-edge clock
//   INIT   - synchronous active-high reset, highest priority
//   LOAD   - start-frame strobe, honoured only while idle
//   VALUE  - probability numerator, captured with LOAD
//   BitOUT - registered stochastic bits, one per stream
//   VALID  - BitOUT holds a frame bit this cycle
//   DONE   - one-cycle pulse alongside the last frame bit
//   BUSY   - FSM is in RUN; LOAD ignored
module stoch_bitgen3
    import stoch_pkg::*;
#(
    parameter int               WIDTH = WIDTH_DEF,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_DEF,
    parameter logic [WIDTH-1:0] SEED0 = SEED0_DEF,
    parameter logic [WIDTH-1:0] SEED1 = SEED1_DEF,
    parameter logic [WIDTH-1:0] SEED2 = SEED2_DEF
) (
    input  logic             CLK,
    input  logic             INIT,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] VALUE,
    output logic [2:0]       BitOUT,
    output logic             VALID,
    output logic             DONE,
    output logic             BUSY
);

    localparam logic [WIDTH-1:0] FRAME_LEN = WIDTH'(frame_len(WIDTH));
    localparam logic [WIDTH-1:0] LAST_CNT  = FRAME_LEN - WIDTH'(1);

    state_t           state_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] value_r;
    logic [2:0]       bit_r;
    logic             valid_r;
    logic             done_r;
    logic             busy_r;

    logic             emit_s;
    logic [WIDTH-1:0] val_sel_s;
    logic [WIDTH-1:0] lfsr0_s, lfsr1_s, lfsr2_s;
    logic [WIDTH-1:0] dec0_s, dec1_s, dec2_s;
    logic [2:0]       cmp_s;

    stoch_lfsr #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED0)) u_lfsr0 (
        .CLK(CLK), .INIT(INIT), .EN(emit_s), .Q(lfsr0_s)
    );
    stoch_lfsr #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED1)) u_lfsr1 (
        .CLK(CLK), .INIT(INIT), .EN(emit_s), .Q(lfsr1_s)
    );
    stoch_lfsr #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED2)) u_lfsr2 (
        .CLK(CLK), .INIT(INIT), .EN(emit_s), .Q(lfsr2_s)
    );

    // Emit edges: the LOAD edge out of IDLE and every RUN edge.
    // INIT suppresses stepping anyway since the LFSRs reseed on it.
    always_comb begin
        emit_s = 1'b0;
        case (state_r)
            IDLE:    emit_s = LOAD;
            RUN:     emit_s = 1'b1;
            default: emit_s = 1'b0;
        endcase
    end

    // On the LOAD edge the new VALUE is compared directly, before value_r
    // has captured it, so the first bit needs no extra cycle.
    always_comb begin
        val_sel_s = value_r;
        if (state_r == IDLE) begin
            val_sel_s = VALUE;
        end else begin
            val_sel_s = value_r;
        end
    end

    // Per-stream comparators; lfsr-1 spans 0..FRAME_LEN-1 once per period.
    always_comb begin
        dec0_s   = lfsr0_s - WIDTH'(1);
        dec1_s   = lfsr1_s - WIDTH'(1);
        dec2_s   = lfsr2_s - WIDTH'(1);
        cmp_s[0] = (dec0_s < val_sel_s);
        cmp_s[1] = (dec1_s < val_sel_s);
        cmp_s[2] = (dec2_s < val_sel_s);
    end

    // Frame FSM, bit counter, value latch and all registered outputs.
    always_ff @(posedge CLK) begin
        if (INIT) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            value_r <= '0;
            bit_r   <= 3'b000;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (LOAD) begin
                        value_r <= VALUE;
                        bit_r   <= cmp_s;
                        valid_r <= 1'b1;
                        cnt_r   <= WIDTH'(1);
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        bit_r   <= 3'b000;
                        valid_r <= 1'b0;
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    bit_r   <= cmp_s;
                    valid_r <= 1'b1;
                    cnt_r   <= cnt_r + WIDTH'(1);
                    // Last bit goes out together with DONE in the first IDLE cycle.
                    if (cnt_r == LAST_CNT) begin
                        state_r <= IDLE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        done_r  <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    bit_r   <= 3'b000;
                    valid_r <= 1'b0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign BitOUT = bit_r;
    assign VALID  = valid_r;
    assign DONE   = done_r;
    assign BUSY   = busy_r;

endmodule
